// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one bit pair per cycle through a two-stage half-sum
// full-add cell, with a start/busy/done handshake and parallel registered result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] qS,
  output logic             qCout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    count;

  logic h1_s;
  logic h1_c;
  logic s;
  logic c_next;

  // Two cascaded half-sum stages form the full-add cell.
  always_comb begin
    h1_s   = a_sh[0] ^ b_sh[0];
    h1_c   = a_sh[0] & b_sh[0];
    s      = h1_s ^ carry;
    c_next = h1_c | (h1_s & carry);
    // The widened shift also covers WIDTH=1, where the new bit is the whole word.
    sum_next = WIDTH'({s, sum_sh} >> 1);
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      qS     <= '0;
      qCout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= Cin;
            count  <= '0;
            sum_sh <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= c_next;
          count  <= count + CW'(1);
          if (count == LAST) begin
            qS    <= sum_next;
            qCout <= c_next;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8 and WIDTH=1) with a queue scoreboard
// filled at each accepting edge and drained when done is observed.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n, start8, Cin8, busy8, done8, qCout8;
  logic [7:0] A8, B8, qS8;
  logic       rst1_n, start1, Cin1, busy1, done1, qCout1;
  logic [0:0] A1, B1, qS1;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [31:0] sb[$];

  logic [7:0] ha[4] = '{8'hC3, 8'h80, 8'h7F, 8'h12};
  logic [7:0] hb[4] = '{8'h3D, 8'h80, 8'h00, 8'hED};
  logic       hc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .A(A8), .B(B8), .Cin(Cin8),
    .busy(busy8), .done(done8), .qS(qS8), .qCout(qCout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
    .busy(busy1), .done(done1), .qS(qS1), .qCout(qCout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic wait_done(input bit w1, output int busy_n, output int done_at);
    busy_n  = 0;
    done_at = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (w1 ? busy1 : busy8) busy_n++;
      if (w1 ? done1 : done8) begin
        done_at = n;
        break;
      end
    end
  endtask

  task automatic sb_check(input string tag, input bit w1);
    logic [31:0] exp_v;
    logic [31:0] obs_v;
    chk({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    exp_v = 32'hDEAD;
    if (sb.size() > 0) exp_v = sb.pop_front();
    obs_v = w1 ? 32'({qCout1, qS1}) : 32'({qCout8, qS8});
    chk({tag, " sum"}, obs_v, exp_v);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input string tag);
    int bn, da;
    @(negedge clk);
    A8 = a; B8 = b; Cin8 = cin; start8 = 1'b1;
    @(posedge clk);
    sb.push_back(32'(a) + 32'(b) + 32'(cin));
    #1 start8 = 1'b0;
    A8 = ~a; B8 = b ^ 8'h5A; Cin8 = ~cin;
    wait_done(1'b0, bn, da);
    chk({tag, " busy_cycles"}, bn, 8);
    chk({tag, " done_at"}, da, 9);
    sb_check(tag, 1'b0);
    @(negedge clk);
    chk({tag, " done_width"}, {busy8, done8}, 2'b00);
  endtask

  initial begin
    int bn, da, nd, prev_cyc;
    logic [7:0] prev_q;
    logic stable_ok;
    logic [2:0] vv;

    rst8_n = 1'b1; rst1_n = 1'b1;
    start8 = 1'b0; A8 = '0; B8 = '0; Cin8 = 1'b0;
    start1 = 1'b0; A1 = '0; B1 = '0; Cin1 = 1'b0;
    #1 rst8_n = 1'b0; rst1_n = 1'b0;
    #1;
    chk("reset8 outputs", {busy8, done8, qCout8, qS8}, 32'd0);
    chk("reset1 outputs", {busy1, done1, qCout1, qS1}, 32'd0);
    repeat (2) @(negedge clk);
    rst8_n = 1'b1; rst1_n = 1'b1;

    // Basic additions
    run8(8'h00, 8'h00, 1'b0, "zero");
    run8(8'hFF, 8'h01, 1'b0, "ff_plus_1");
    run8(8'h5A, 8'hA5, 1'b1, "5a_a5_c");
    run8(8'h3C, 8'h21, 1'b0, "3c_21");

    // start re-pulsed during RUN is ignored; qS holds until done
    prev_q = qS8;
    @(negedge clk);
    A8 = 8'h92; B8 = 8'h84; Cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    sb.push_back(32'h116);
    #1 start8 = 1'b0;
    stable_ok = 1'b1;
    bn = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 3) begin start8 = 1'b1; A8 = 8'h01; B8 = 8'h01; end
      if (n == 4) start8 = 1'b0;
      if (busy8) bn++;
      if (qS8 !== prev_q || qCout8 !== 1'b0 || done8 !== 1'b0) stable_ok = 1'b0;
    end
    chk("ignore busy_cycles", bn, 8);
    chk("ignore qS_stable", stable_ok, 1'b1);
    @(negedge clk);
    chk("ignore done", done8, 1'b1);
    sb_check("ignore", 1'b0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("ignore single_done", nd, 0);

    // Asynchronous reset in the 4th RUN cycle
    @(negedge clk);
    A8 = 8'h77; B8 = 8'h11; Cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    sb.push_back(32'h88);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst busy_before", busy8, 1'b1);
    #2 rst8_n = 1'b0;
    #1;
    chk("midrst async_clear", {busy8, done8, qCout8, qS8}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("midrst held", {busy8, done8, qCout8, qS8}, 32'd0);
    rst8_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("midrst no_done", nd, 0);
    run8(8'h10, 8'h20, 1'b0, "post_rst");

    // start held high: one acceptance every WIDTH+2 cycles
    @(negedge clk);
    A8 = ha[0]; B8 = hb[0]; Cin8 = hc[0]; start8 = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      sb.push_back(32'(ha[k]) + 32'(hb[k]) + 32'(hc[k]));
      #1;
      if (k < 3) begin
        A8 = ha[k+1]; B8 = hb[k+1]; Cin8 = hc[k+1];
      end else begin
        start8 = 1'b0;
      end
      wait_done(1'b0, bn, da);
      chk($sformatf("held%0d busy_cycles", k), bn, 8);
      chk($sformatf("held%0d done_at", k), da, 9);
      if (k > 0) chk($sformatf("held%0d period", k), cyc - prev_cyc, 10);
      prev_cyc = cyc;
      sb_check($sformatf("held%0d", k), 1'b0);
      @(posedge clk);
    end

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      @(negedge clk);
      A1 = vv[2]; B1 = vv[1]; Cin1 = vv[0]; start1 = 1'b1;
      @(posedge clk);
      sb.push_back(32'(vv[2]) + 32'(vv[1]) + 32'(vv[0]));
      #1 start1 = 1'b0;
      wait_done(1'b1, bn, da);
      chk($sformatf("w1_%0d busy_cycles", v), bn, 1);
      chk($sformatf("w1_%0d done_at", v), da, 2);
      sb_check($sformatf("w1_%0d", v), 1'b1);
      @(negedge clk);
      chk($sformatf("w1_%0d done_width", v), {busy1, done1}, 2'b00);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
